// File: rtl/pll_rst_pkg.sv
// Shared types and constants for the PLL reset sequencer.
//   pll_rst_state_t : sequencer FSM states
//   Def*            : default parameter values
//   cnt_w()         : width of the shared state counter
package pll_rst_pkg;

  typedef enum logic [2:0] {
    StPllRst,
    StWaitLock,
    StFilter,
    StRelease,
    StRun
  } pll_rst_state_t;

  localparam int unsigned DefPllRstCycles = 16;
  localparam int unsigned DefLockStable   = 64;
  localparam int unsigned DefLockTimeout  = 65536;
  localparam int unsigned DefStepCycles   = 8;
  localparam int unsigned DefNumOut       = 3;

  // Counter only ever needs to reach (longest interval - 1); never narrower than 1 bit.
  function automatic int unsigned cnt_w(input int unsigned a, input int unsigned b,
                                        input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return (m <= 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level signal.
//   clk_i  : destination clock
//   rst_ni : asynchronous active-low reset (flops clear to 0)
//   d_i    : asynchronous input
//   q_o    : synchronized output, 2 cycles of latency
module sync_2ff (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pll_reset_sequencer.sv
// Drives the PLL reset, retries lock on timeout, filters lock and releases
// downstream active-low resets in ascending order.
//   clk          : PLL output clock
//   rst_n        : asynchronous active-low reset
//   locked_i     : PLL lock, asynchronous
//   soft_rst_i   : single-cycle request to re-run the release sequence
//   pll_rst_o    : active-high PLL reset
//   rst_n_o      : sequenced active-low resets, bit 0 released first
//   ready_o      : all of rst_n_o released
//   relock_cnt_o : saturating count of lock losses after first lock
module pll_reset_sequencer
  import pll_rst_pkg::*;
#(
  parameter int unsigned PLL_RST_CYCLES = DefPllRstCycles,
  parameter int unsigned LOCK_STABLE    = DefLockStable,
  parameter int unsigned LOCK_TIMEOUT   = DefLockTimeout,
  parameter int unsigned STEP_CYCLES    = DefStepCycles,
  parameter int unsigned NUM_OUT        = DefNumOut
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               locked_i,
  input  logic               soft_rst_i,
  output logic               pll_rst_o,
  output logic [NUM_OUT-1:0] rst_n_o,
  output logic               ready_o,
  output logic [7:0]         relock_cnt_o
);

  localparam int unsigned CntW = cnt_w(PLL_RST_CYCLES, LOCK_STABLE, LOCK_TIMEOUT, STEP_CYCLES);
  localparam int unsigned IdxW = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;

  localparam logic [CntW-1:0] PllRstLast  = CntW'(PLL_RST_CYCLES - 1);
  localparam logic [CntW-1:0] TimeoutLast = CntW'(LOCK_TIMEOUT - 1);
  localparam logic [CntW-1:0] StableLast  = CntW'(LOCK_STABLE - 1);
  localparam logic [CntW-1:0] StepLast    = CntW'(STEP_CYCLES - 1);
  localparam logic [IdxW-1:0] IdxLast     = IdxW'(NUM_OUT - 1);

  logic locked_s;

  sync_2ff u_sync_locked (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .d_i    (locked_i),
    .q_o    (locked_s)
  );

  pll_rst_state_t     state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [IdxW-1:0]    idx_q, idx_d;
  logic [NUM_OUT-1:0] rst_vec_q, rst_vec_d;
  logic [7:0]         relock_q, relock_d;
  logic               pll_rst_q, pll_rst_d;
  logic               ready_q, ready_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CntW'(1);
    idx_d     = idx_q;
    rst_vec_d = rst_vec_q;
    relock_d  = relock_q;

    unique case (state_q)
      StPllRst: begin
        if (cnt_q == PllRstLast) begin
          state_d = StWaitLock;
          cnt_d   = '0;
        end
      end
      StWaitLock: begin
        if (locked_s) begin
          state_d = StFilter;
          cnt_d   = '0;
        end else if (cnt_q == TimeoutLast) begin
          state_d = StPllRst;
          cnt_d   = '0;
        end
      end
      StFilter: begin
        if (!locked_s) begin
          state_d = StWaitLock;
          cnt_d   = '0;
        end else if (cnt_q == StableLast) begin
          state_d = StRelease;
          cnt_d   = '0;
          idx_d   = '0;
        end
      end
      StRelease, StRun: begin
        // Lock loss takes priority over a simultaneous soft reset.
        if (!locked_s) begin
          state_d   = StPllRst;
          cnt_d     = '0;
          rst_vec_d = '0;
          if (relock_q != 8'hFF) relock_d = relock_q + 8'd1;
        end else if (soft_rst_i) begin
          state_d   = StRelease;
          cnt_d     = '0;
          idx_d     = '0;
          rst_vec_d = '0;
        end else if (state_q == StRun) begin
          cnt_d = '0;
        end else if (cnt_q == StepLast) begin
          cnt_d = '0;
          for (int unsigned i = 0; i < NUM_OUT; i++) begin
            if (idx_q == IdxW'(i)) rst_vec_d[i] = 1'b1;
          end
          if (idx_q == IdxLast) begin
            state_d = StRun;
          end else begin
            idx_d = idx_q + IdxW'(1);
          end
        end
      end
      default: begin
        state_d = StPllRst;
        cnt_d   = '0;
      end
    endcase

    // Outputs are registered from the next state so they line up with it.
    pll_rst_d = (state_d == StPllRst);
    ready_d   = (state_d == StRun);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StPllRst;
      cnt_q     <= '0;
      idx_q     <= '0;
      rst_vec_q <= '0;
      relock_q  <= '0;
      pll_rst_q <= 1'b1;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      rst_vec_q <= rst_vec_d;
      relock_q  <= relock_d;
      pll_rst_q <= pll_rst_d;
      ready_q   <= ready_d;
    end
  end

  assign pll_rst_o    = pll_rst_q;
  assign rst_n_o      = rst_vec_q;
  assign ready_o      = ready_q;
  assign relock_cnt_o = relock_q;

endmodule
